dut: RTL and testbench
======================

DUT -- requirements
Module: dut

Interface
REQ-001 The block SHALL expose parameter NKEYS, default 20, meaning the number of keys inserted and then looked up (legal range 0..64).
REQ-002 The block SHALL expose parameter MAX_KICKS, default 16, meaning the maximum evictions allowed per insert.
REQ-003 The block SHALL expose parameter SEED, default 16'hACE1, meaning the key-generator start value (nonzero).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 hpr_abend_syndrome  output  8  run status: 8'hFF running; any other value means finished, with that value as the result code.

Function
REQ-007 Storage SHALL be two cuckoo tables, T0 and T1, of 16 entries each; each entry holds valid (1 bit), key (16 bits) and value (16 bits).
REQ-008 Hash functions SHALL be h0(k) = k[3:0]^k[11:8] and h1(k) = k[7:4]^k[15:12]^4'hA.
REQ-009 Key generator SHALL be a 16-bit Fibonacci LFSR: taps 16,14,13,11; next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}; first key = SEED; it never yields 0.
REQ-010 The value stored for key k SHALL be ~k.
REQ-011 FSM states: INS_START, INS_PROBE, INS_KICK, LKP_START, LKP_PROBE, MISS_CHK, DONE.
REQ-012 INS_START: if inserted-count == NKEYS, go to LKP_START with the LFSR reloaded to SEED; else load the current key and value into the carry register, set kick=0, and advance the LFSR.
REQ-013 INS_PROBE (1 cycle): if the carry key equals a valid T0[h0] or T1[h1] key, overwrite that value and go to INS_START.
REQ-014 INS_PROBE otherwise: if T0[h0] is invalid, write the carry there; else if T1[h1] is invalid, write it there; either write returns to INS_START with count+1; if both are full, go to INS_KICK.
REQ-015 INS_KICK (1 cycle per kick): swap the carry with the occupant of the alternate table (T0 on even kick, T1 on odd) at that table's hash of the carry key.
REQ-016 INS_KICK continued: kick+1; retry INS_PROBE with the displaced entry; if kick reaches MAX_KICKS, go to DONE with syndrome 8'h02.
REQ-017 LKP_PROBE (1 cycle per key): hit means a valid T0[h0(k)] or T1[h1(k)] entry with key == k; miss, or value != ~k, SHALL go to DONE with syndrome 8'h03; after NKEYS keys, go to MISS_CHK.
REQ-018 MISS_CHK: a lookup of key 16'h0000 SHALL miss, giving DONE with 8'h00; a hit gives DONE with 8'h04.
REQ-019 DONE SHALL hold the syndrome and all state until reset; hpr_abend_syndrome is registered, never X after the first reset.
REQ-020 Behaviour SHALL be fully deterministic; identical parameters give identical cycle counts on every run.
REQ-021 Worst-case completion SHALL be at most NKEYS*(2*MAX_KICKS+4)+8 cycles after reset deassertion.
REQ-022 NKEYS > 32 exceeds capacity, and completion SHALL then be syndrome 8'h02.

Reset
REQ-023 While reset is high at a clock edge: syndrome <= 8'hFF, all valid bits <= 0, LFSR <= SEED, counters <= 0, state <= INS_START.
REQ-024 Reset asserted mid-operation, including in DONE, SHALL abort immediately; the rerun after release SHALL repeat the first run exactly, cycle for cycle.
REQ-025 Table key and value fields need no reset; only valid bits are reset.

Verification
REQ-026 Default params, reset high for 5 cycles then low -> syndrome 8'hFF during and after reset, then 8'h00 within 2000 cycles, held for 100 further cycles.
REQ-027 Default params, reset reasserted 50 cycles into the run, then released -> 8'hFF the next cycle; completes 8'h00 with a cycle count identical to an uninterrupted run.
REQ-028 NKEYS=0 -> 8'h00 within 10 cycles of reset release, via the MISS_CHK path only.
REQ-029 NKEYS=33 -> 8'h02; no 8'h03 or 8'h04 ever appears.
REQ-030 Default params with a bench force of one valid T1 value to 16'h0000 after the insert phase -> 8'h03.
REQ-031 All runs: syndrome changes value at most once between reset release and completion (8'hFF to the final code).

Source files
------------

// File: rtl/dut.sv
// -----------------------------------------------------------------------------
// dut -- self-running cuckoo hash table exerciser.
//
// Generates NKEYS pseudo-random 16-bit keys from an LFSR and inserts each one,
// with value ~key, into a two-table cuckoo hash (T0/T1, 16 entries each).
// Colliding entries are evicted alternately from T0 and T1, up to MAX_KICKS
// evictions per insert. The LFSR is then restarted and every key is looked up
// and its value checked. Finally key 0, which the LFSR never produces, must
// miss. The outcome is reported on a registered status byte.
//
// Ports
//   clk                 in   1  clock, all state updates on the rising edge
//   reset               in   1  synchronous, active-high reset
//   hpr_abend_syndrome  out  8  8'hFF while running, otherwise the result:
//                                 8'h00  all keys found, key 0 missed
//                                 8'h02  an insert ran out of evictions
//                                 8'h03  a lookup missed or returned a bad value
//                                 8'h04  key 0 was (wrongly) found
// -----------------------------------------------------------------------------
module dut #(
    parameter int          NKEYS     = 20,
    parameter int          MAX_KICKS = 16,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] hpr_abend_syndrome
);

    localparam logic [6:0] NKEYS_C     = 7'(NKEYS);
    localparam logic [7:0] MAX_KICKS_C = 8'(MAX_KICKS);

    localparam logic [7:0] SYN_RUNNING   = 8'hFF;
    localparam logic [7:0] SYN_PASS      = 8'h00;
    localparam logic [7:0] SYN_FULL      = 8'h02;
    localparam logic [7:0] SYN_LOOKUP    = 8'h03;
    localparam logic [7:0] SYN_FALSE_HIT = 8'h04;

    typedef enum logic [2:0] {
        INS_START,
        INS_PROBE,
        INS_KICK,
        LKP_START,
        LKP_PROBE,
        MISS_CHK,
        DONE
    } state_t;

    // -------------------------------------------------------------------------
    // Hash functions and key generator step
    // -------------------------------------------------------------------------
    function automatic logic [3:0] h0(input logic [15:0] k);
        return k[3:0] ^ k[11:8];
    endfunction

    function automatic logic [3:0] h1(input logic [15:0] k);
        return k[7:4] ^ k[15:12] ^ 4'hA;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] carry_key;   // key being inserted, displaced, or looked up
    logic [15:0] carry_val;
    logic [6:0]  ins_count;
    logic [6:0]  lkp_count;
    logic [7:0]  kick;

    logic [15:0]       t0_valid;
    logic [15:0]       t1_valid;
    logic [15:0][15:0] t0_key;
    logic [15:0][15:0] t0_val;
    logic [15:0][15:0] t1_key;
    logic [15:0][15:0] t1_val;

    // -------------------------------------------------------------------------
    // Probe of both tables for the carry key. The same logic serves inserts,
    // lookups and the final key-0 check (carry_key is cleared for that).
    // -------------------------------------------------------------------------
    logic [3:0]  c_h0;
    logic [3:0]  c_h1;
    logic        t0_hit;
    logic        t1_hit;
    logic        lkp_ok;
    logic [15:0] victim_key;
    logic [15:0] victim_val;
    logic        t0_we;
    logic        t1_we;

    assign c_h0   = h0(carry_key);
    assign c_h1   = h1(carry_key);
    assign t0_hit = t0_valid[c_h0] && (t0_key[c_h0] == carry_key);
    assign t1_hit = t1_valid[c_h1] && (t1_key[c_h1] == carry_key);
    assign lkp_ok = (t0_hit && (t0_val[c_h0] == ~carry_key)) ||
                    (t1_hit && (t1_val[c_h1] == ~carry_key));

    // Even kicks evict from T0, odd kicks from T1.
    assign victim_key = kick[0] ? t1_key[c_h1] : t0_key[c_h0];
    assign victim_val = kick[0] ? t1_val[c_h1] : t0_val[c_h0];

    // Table write enables; every write stores the carry at its own hash slot.
    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path can leave it unassigned and infer a latch.
        t0_we = 1'b0;
        t1_we = 1'b0;
        if (!reset) begin
            unique case (state)
                INS_PROBE: begin
                    if (t0_hit)                t0_we = 1'b1;  // refresh value
                    else if (t1_hit)           t1_we = 1'b1;  // refresh value
                    else if (!t0_valid[c_h0])  t0_we = 1'b1;
                    else if (!t1_valid[c_h1])  t1_we = 1'b1;
                end
                INS_KICK: begin
                    if (!kick[0]) t0_we = 1'b1;
                    else          t1_we = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Table payload storage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: key/value fields carry no reset; the valid bits, which are
        // reset, decide whether an entry means anything.
        if (t0_we) begin
            t0_key[c_h0] <= carry_key;
            t0_val[c_h0] <= carry_val;
        end
        if (t1_we) begin
            t1_key[c_h1] <= carry_key;
            t1_val[c_h1] <= carry_val;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered status output
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= INS_START;
            hpr_abend_syndrome <= SYN_RUNNING;
            lfsr               <= SEED;
            carry_key          <= '0;
            carry_val          <= '0;
            ins_count          <= '0;
            lkp_count          <= '0;
            kick               <= '0;
            t0_valid           <= '0;
            t1_valid           <= '0;
        end else begin
            if (t0_we) t0_valid[c_h0] <= 1'b1;
            if (t1_we) t1_valid[c_h1] <= 1'b1;

            unique case (state)
                INS_START: begin
                    if (ins_count == NKEYS_C) begin
                        lfsr  <= SEED;   // replay the same key sequence
                        state <= LKP_START;
                    end else begin
                        carry_key <= lfsr;
                        carry_val <= ~lfsr;
                        kick      <= '0;
                        lfsr      <= lfsr_step(lfsr);
                        state     <= INS_PROBE;
                    end
                end

                INS_PROBE: begin
                    if (t0_hit || t1_hit) begin
                        state <= INS_START;
                    end else if (!t0_valid[c_h0] || !t1_valid[c_h1]) begin
                        ins_count <= ins_count + 7'd1;
                        state     <= INS_START;
                    end else begin
                        state <= INS_KICK;
                    end
                end

                INS_KICK: begin
                    // NOTE: non-blocking assignment lets the carry pick up the
                    // old occupant while the table stores the carry on the
                    // same edge -- a clean swap with no ordering hazard.
                    carry_key <= victim_key;
                    carry_val <= victim_val;
                    kick      <= kick + 8'd1;
                    if (kick + 8'd1 >= MAX_KICKS_C) begin
                        hpr_abend_syndrome <= SYN_FULL;
                        state              <= DONE;
                    end else begin
                        state <= INS_PROBE;
                    end
                end

                LKP_START: begin
                    if (lkp_count == NKEYS_C) begin
                        carry_key <= '0;  // key 0 is never generated
                        state     <= MISS_CHK;
                    end else begin
                        carry_key <= lfsr;
                        lfsr      <= lfsr_step(lfsr);
                        state     <= LKP_PROBE;
                    end
                end

                LKP_PROBE: begin
                    if (!lkp_ok) begin
                        hpr_abend_syndrome <= SYN_LOOKUP;
                        state              <= DONE;
                    end else begin
                        lkp_count <= lkp_count + 7'd1;
                        state     <= LKP_START;
                    end
                end

                MISS_CHK: begin
                    hpr_abend_syndrome <= (t0_hit || t1_hit) ? SYN_FALSE_HIT : SYN_PASS;
                    state              <= DONE;
                end

                DONE: ;  // hold everything until reset

                default: state <= INS_START;
            endcase
        end
    end

endmodule

// File: tb/tb_dut.sv
// -----------------------------------------------------------------------------
// tb_dut -- scoreboard bench for the cuckoo hash exerciser.
//
// Four instances: default parameters (normal and mid-run reset), default with
// one T1 value corrupted after the insert phase, NKEYS=0 and NKEYS=33.
// Each test pushes its expected final syndrome into a queue before releasing
// reset; a monitor pops and compares whenever an instance's syndrome leaves
// 8'hFF, and flags any further change before the next reset.
// -----------------------------------------------------------------------------
module tb_dut;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [4];
    logic [7:0] syn [4];

    dut u_def (
        .clk                (clk),
        .reset              (rst[0]),
        .hpr_abend_syndrome (syn[0])
    );

    dut u_frc (
        .clk                (clk),
        .reset              (rst[1]),
        .hpr_abend_syndrome (syn[1])
    );

    dut #(.NKEYS(0)) u_zero (
        .clk                (clk),
        .reset              (rst[2]),
        .hpr_abend_syndrome (syn[2])
    );

    dut #(.NKEYS(33)) u_over (
        .clk                (clk),
        .reset              (rst[3]),
        .hpr_abend_syndrome (syn[3])
    );

    typedef struct {
        int         inst;
        logic [7:0] code;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    bit         rst_at_edge [4];
    bit         rst_checked [4];
    bit         done_seen   [4];
    int         done_cyc    [4];
    int         rel_cyc     [4];
    logic [7:0] prev        [4];

    logic [15:0][15:0] frc_val;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Cycle counter and the reset value each DUT actually saw at the last edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 4; i++) rst_at_edge[i] <= rst[i];
    end

    // Monitor: syndrome leaving 8'hFF is the DUT's single response per run.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst_at_edge[i]) begin
                if (!rst_checked[i]) begin
                    check($sformatf("reset_ff[%0d]", i), 32'(syn[i]), 32'hFF);
                    rst_checked[i] = 1'b1;
                end
                prev[i] = 8'hFF;
            end else begin
                rst_checked[i] = 1'b0;
                if (syn[i] !== prev[i]) begin
                    if (prev[i] == 8'hFF && !done_seen[i]) begin
                        done_seen[i] = 1'b1;
                        done_cyc[i]  = cyc;
                        if (exp_q.size() == 0) begin
                            check($sformatf("unexpected_completion[%0d]", i), 32'(syn[i]), 32'hFF);
                        end else begin
                            exp_t e;
                            e = exp_q.pop_front();
                            check({e.name, "_instance"}, 32'(i), 32'(e.inst));
                            check({e.name, "_code"}, 32'(syn[i]), 32'(e.code));
                        end
                    end else begin
                        check($sformatf("syndrome_changed_twice[%0d]", i), 32'(syn[i]), 32'(prev[i]));
                    end
                    prev[i] = syn[i];
                end
            end
        end
    end

    task automatic push_exp(input int inst, input logic [7:0] code, input string name);
        exp_t e;
        e.inst = inst;
        e.code = code;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Hold reset for n edges, then release; the next edge is run cycle 1.
    task automatic apply_reset(input int i, input int n);
        @(posedge clk);
        #1;
        rst[i] = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst[i]       = 1'b0;
        done_seen[i] = 1'b0;
        rel_cyc[i]   = cyc;
    endtask

    // Bounded wait for completion; lat = edges from release to final syndrome.
    task automatic wait_done(input int i, input int budget, input string name, output int lat);
        int n;
        n = 0;
        while (!done_seen[i] && n < budget) begin
            @(posedge clk);
            n++;
        end
        check({name, "_completes"}, 32'(done_seen[i]), 32'd1);
        lat = done_seen[i] ? (done_cyc[i] - rel_cyc[i]) : budget;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat_a;
        int lat_b;
        int lat;
        int bad;
        int n;
        int found;

        for (int i = 0; i < 4; i++) begin
            rst[i]  = 1'b1;
            prev[i] = 8'hFF;
        end

        // ---- Default run: FF through reset and after release, then 00, held.
        push_exp(0, 8'h00, "default_run");
        apply_reset(0, 5);
        @(negedge clk);
        check("ff_after_release", 32'(syn[0]), 32'hFF);
        wait_done(0, 2000, "default_run", lat_a);
        check("default_within_bound", 32'(lat_a <= 20 * (2 * 16 + 4) + 8), 32'd1);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (syn[0] !== 8'h00) bad++;
        end
        check("done_held_100_cycles", 32'(bad), 32'd0);

        // ---- Reset from DONE, then reset again 50 cycles into the rerun.
        apply_reset(0, 1);
        @(negedge clk);
        check("ff_after_done_reset", 32'(syn[0]), 32'hFF);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("running_at_50", 32'(syn[0]), 32'hFF);
        push_exp(0, 8'h00, "rerun_after_abort");
        apply_reset(0, 1);
        @(negedge clk);
        check("ff_after_midrun_reset", 32'(syn[0]), 32'hFF);
        wait_done(0, 2000, "rerun_after_abort", lat_b);
        check("rerun_same_cycle_count", 32'(lat_b), 32'(lat_a));

        // ---- NKEYS=0: straight through MISS_CHK.
        push_exp(2, 8'h00, "nkeys0");
        apply_reset(2, 5);
        wait_done(2, 10, "nkeys0", lat);
        check("nkeys0_within_10", 32'(lat <= 10), 32'd1);

        // ---- NKEYS=33: over capacity, must end on eviction limit.
        push_exp(3, 8'h02, "nkeys33_overflow");
        apply_reset(3, 5);
        wait_done(3, 2000, "nkeys33_overflow", lat);
        check("nkeys33_within_bound", 32'(lat <= 33 * (2 * 16 + 4) + 8), 32'd1);

        // ---- Corrupt one T1 value after the insert phase: lookup must fail.
        push_exp(1, 8'h03, "corrupted_value");
        apply_reset(1, 5);
        n = 0;
        while (u_frc.ins_count != 7'd20 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("frc_insert_phase_done", 32'(u_frc.ins_count == 7'd20), 32'd1);
        found = -1;
        frc_val = u_frc.t1_val;
        for (int i = 0; i < 16; i++) begin
            if (u_frc.t1_valid[i] && found < 0) found = i;
        end
        check("frc_t1_entry_found", 32'(found >= 0), 32'd1);
        if (found >= 0) begin
            frc_val[4'(found)] = 16'h0000;
            force u_frc.t1_val = frc_val;
        end
        wait_done(1, 2000, "corrupted_value", lat);
        release u_frc.t1_val;

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
